// File: rtl/uart_tx_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit arbiter:
//   - arb_state_e    : arbiter FSM state encoding
//   - DATA_WIDTH_DEF : default byte width per frame
//   - TIMEOUT_CYCLES : cycles the transmitter may take to raise its busy flag
//   - id_width()     : width of a requester index for a given requester count
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int TIMEOUT_CYCLES = 4;
  localparam int TIMEOUT_W      = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_ISSUE     = 2'b01,
    ST_WAIT_BUSY = 2'b10,
    ST_WAIT_DONE = 2'b11
  } arb_state_e;

  // Index width, never below one bit so a single-bit id is still representable.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester side and transmitter side signals of the arbiter.
//   req        : per-requester frame request (held until its gnt bit is seen)
//   req_data   : packed bytes, requester i owns [i*DATA_WIDTH +: DATA_WIDTH]
//   req_mask   : 1 = requester disabled
//   tx_busy    : busy flag from the UART transmitter
//   gnt        : one-hot one-cycle pulse, byte of requester i accepted
//   tx_data_valid / tx_p_data : frame start pulse and byte to the transmitter
//   active_id  : requester currently owning the transmitter
//   arb_busy   : high whenever the arbiter is not idle
//   drop       : one-cycle pulse, transmitter never acknowledged the frame
// Modports: master = arbiter side, slave = requesters/transmitter side.
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  localparam int ID_W = id_width(N_REQ);

  logic [N_REQ-1:0]            req;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            req_mask;
  logic                        tx_busy;
  logic [N_REQ-1:0]            gnt;
  logic                        tx_data_valid;
  logic [DATA_WIDTH-1:0]       tx_p_data;
  logic [ID_W-1:0]             active_id;
  logic                        arb_busy;
  logic                        drop;

  modport master (
    input  req, req_data, req_mask, tx_busy,
    output gnt, tx_data_valid, tx_p_data, active_id, arb_busy, drop
  );

  modport slave (
    output req, req_data, req_mask, tx_busy,
    input  gnt, tx_data_valid, tx_p_data, active_id, arb_busy, drop
  );

endinterface

// File: rtl/uart_tx_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: starting at last_grant+1 and wrapping at
// N_REQ-1 back to 0, the first asserted req bit wins.
//   req        : eligible request vector (already masked)
//   last_grant : index granted most recently
//   winner     : selected index (0 when nothing is requesting)
//   valid      : at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_grant,
  output logic [ID_W-1:0]  winner,
  output logic             valid
);

  // Rotating priority search; the first hit along the rotation is kept.
  always_comb begin
    int   idx;
    logic hit;
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    hit    = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx    = (int'(last_grant) + k) % N_REQ;
      hit    = ~valid & req[idx];
      winner = hit ? ID_W'(idx) : winner;
      valid  = valid | hit;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between N_REQ requesters. An IDLE decision
// picks a round-robin winner, latches its byte and issues a one-cycle frame
// start; the arbiter then waits for the transmitter to go busy (or times out
// and pulses drop) and for it to finish before deciding again.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : uart_tx_arbiter_if.master (requesters + transmitter handshake)
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_arbiter_if.master   bus
);

  localparam int ID_W = id_width(N_REQ);
  // Requester 0 wins first after reset because the search starts at last+1.
  localparam logic [ID_W-1:0]      LAST_RST = ID_W'(N_REQ - 1);
  localparam logic [TIMEOUT_W-1:0] TO_LAST  = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e            state_q, state_d;
  logic [N_REQ-1:0]      gnt_q, gnt_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [ID_W-1:0]       last_q, last_d;
  logic                  busy_q, busy_d;
  logic                  drop_q, drop_d;
  logic [TIMEOUT_W-1:0]  to_cnt_q, to_cnt_d;

  logic [N_REQ-1:0]      eligible;
  logic [ID_W-1:0]       rr_winner;
  logic                  rr_valid;

  // Masked requesters are invisible to the decision made this cycle.
  assign eligible = bus.req & ~bus.req_mask;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .req        (eligible),
    .last_grant (last_q),
    .winner     (rr_winner),
    .valid      (rr_valid)
  );

  // Next-state, data latch and pulse generation.
  always_comb begin
    state_d  = state_q;
    gnt_d    = '0;
    valid_d  = 1'b0;
    drop_d   = 1'b0;
    data_d   = data_q;
    id_d     = id_q;
    last_d   = last_q;
    to_cnt_d = to_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!bus.tx_busy && rr_valid) begin
          // gnt/valid are registered, so they are high during ISSUE.
          state_d          = ST_ISSUE;
          data_d           = bus.req_data[int'(rr_winner)*DATA_WIDTH +: DATA_WIDTH];
          id_d             = rr_winner;
          gnt_d[rr_winner] = 1'b1;
          valid_d          = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d  = ST_WAIT_BUSY;
        last_d   = id_q;
        to_cnt_d = '0;
      end
      ST_WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = ST_IDLE;
          drop_d  = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TIMEOUT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      id_q     <= '0;
      last_q   <= LAST_RST;
      busy_q   <= 1'b0;
      drop_q   <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      id_q     <= id_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      drop_q   <= drop_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  assign bus.gnt           = gnt_q;
  assign bus.tx_data_valid = valid_q;
  assign bus.tx_p_data     = data_q;
  assign bus.active_id     = id_q;
  assign bus.arb_busy      = busy_q;
  assign bus.drop          = drop_q;

endmodule
